// File: rtl/btb_update_ctrl_if.sv
// rtl/btb_update_ctrl_if.sv - EX/IF/BTB-side signal bundle for the BTB write-port controller
//
// Purpose: groups the update handshake, flush control/status and BTB write
// port of btb_update_ctrl into a single interface.
// Modports:
//   master - the environment (EX, IF, BTB): drives upd_valid/upd_pc/upd_target/flush_req,
//            observes upd_ready, flush_busy, lookup_block and wr_*.
//   slave  - btb_update_ctrl itself.
interface btb_update_ctrl_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INDEX_WIDTH = 10,
  parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH
);
  logic                   upd_valid;
  logic [ADDR_WIDTH-1:0]  upd_pc;
  logic [ADDR_WIDTH-1:0]  upd_target;
  logic                   upd_ready;
  logic                   flush_req;
  logic                   flush_busy;
  logic                   lookup_block;
  logic                   wr_en;
  logic [INDEX_WIDTH-1:0] wr_index;
  logic [TAG_WIDTH-1:0]   wr_tag;
  logic [ADDR_WIDTH-1:0]  wr_target;
  logic                   wr_vld;

  modport master (
    output upd_valid, upd_pc, upd_target, flush_req,
    input  upd_ready, flush_busy, lookup_block,
    input  wr_en, wr_index, wr_tag, wr_target, wr_vld
  );

  modport slave (
    input  upd_valid, upd_pc, upd_target, flush_req,
    output upd_ready, flush_busy, lookup_block,
    output wr_en, wr_index, wr_tag, wr_target, wr_vld
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write-port controller: update FIFO plus invalidation sweep
//
// Purpose: queues taken-branch updates from EX, sweeps every BTB entry invalid
// after reset and on flush_req, and drives the BTB's single registered write port.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - btb_update_ctrl_if.slave: upd_* handshake, flush_req/flush_busy,
//              lookup_block to IF, registered wr_* BTB write port
module btb_update_ctrl #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INDEX_WIDTH = 10,
  parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  btb_update_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] cnt;

  logic [ADDR_WIDTH-1:0]  fifo_pc  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_tgt [FIFO_DEPTH];
  logic [PTR_W-1:0]       wptr;
  logic [PTR_W-1:0]       rptr;
  logic [PTR_W:0]         occ;

  logic                   wr_en_q;
  logic [INDEX_WIDTH-1:0] wr_index_q;
  logic [TAG_WIDTH-1:0]   wr_tag_q;
  logic [ADDR_WIDTH-1:0]  wr_target_q;
  logic                   wr_vld_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);

  // A flush in the same cycle blocks both the enqueue and the pop, so the
  // queue is cleared without any entry slipping through.
  assign bus.upd_ready = (state == IDLE) && !full && !bus.flush_req;
  assign push          = bus.upd_valid && bus.upd_ready;
  assign pop           = (state == IDLE) && !empty && !bus.flush_req;

  assign bus.flush_busy   = (state == SWEEP);
  assign bus.lookup_block = (state == SWEEP);

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_index  = wr_index_q;
  assign bus.wr_tag    = wr_tag_q;
  assign bus.wr_target = wr_target_q;
  assign bus.wr_vld    = wr_vld_q;

  // Queue storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wptr]  <= bus.upd_pc;
      fifo_tgt[wptr] <= bus.upd_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SWEEP;
      cnt         <= '0;
      wptr        <= '0;
      rptr        <= '0;
      occ         <= '0;
      wr_en_q     <= 1'b0;
      wr_index_q  <= '0;
      wr_tag_q    <= '0;
      wr_target_q <= '0;
      wr_vld_q    <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          wr_en_q     <= 1'b1;
          wr_index_q  <= cnt;
          wr_tag_q    <= '0;
          wr_target_q <= '0;
          wr_vld_q    <= 1'b0;
          // A flush mid-sweep restarts from index 0 after the current write.
          if (bus.flush_req) begin
            cnt <= '0;
          end else if (cnt == LAST_IDX) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + INDEX_WIDTH'(1);
          end
        end

        IDLE: begin
          if (bus.flush_req) begin
            state   <= SWEEP;
            cnt     <= '0;
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            wr_en_q <= 1'b0;
          end else begin
            wr_en_q <= pop;
            if (pop) begin
              wr_index_q  <= fifo_pc[rptr][INDEX_WIDTH-1:0];
              wr_tag_q    <= fifo_pc[rptr][ADDR_WIDTH-1:INDEX_WIDTH];
              wr_target_q <= fifo_tgt[rptr];
              wr_vld_q    <= 1'b1;
              rptr        <= rptr + PTR_W'(1);
            end
            if (push) begin
              wptr <= wptr + PTR_W'(1);
            end
            case ({push, pop})
              2'b10:   occ <= occ + (PTR_W+1)'(1);
              2'b01:   occ <= occ - (PTR_W+1)'(1);
              default: occ <= occ;
            endcase
          end
        end

        default: state <= SWEEP;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - self-checking bench for btb_update_ctrl against a queue model
module tb_btb_update_ctrl;
  localparam int AW    = 16;
  localparam int IW    = 4;
  localparam int TW    = AW - IW;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << IW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  btb_update_ctrl_if #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW)) bus ();

  btb_update_ctrl #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sweep flag and position plus a queue of pending updates.
  bit               m_sweep;
  int               m_idx;
  logic [2*AW-1:0]  m_q[$];
  logic             exp_en;
  logic [IW-1:0]    exp_idx;
  logic [TW-1:0]    exp_tag;
  logic [AW-1:0]    exp_tgt;
  logic             exp_vld;
  logic             exp_ready;
  logic             seen_ready;

  task automatic model_reset();
    m_sweep = 1'b1;
    m_idx   = 0;
    m_q.delete();
    exp_en  = 1'b0;
    exp_idx = '0;
    exp_tag = '0;
    exp_tgt = '0;
    exp_vld = 1'b0;
  endtask

  // Applies one cycle of inputs (called at a falling edge), advances the model
  // across the rising edge and returns at the next falling edge.
  task automatic cycle(input bit v, input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input bit fl);
    logic [2*AW-1:0] e;
    bus.upd_valid  = v;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.flush_req  = fl;
    #1;
    seen_ready = bus.upd_ready;
    exp_ready  = !m_sweep && (m_q.size() < DEPTH) && !fl;
    @(posedge clk);
    if (m_sweep) begin
      exp_en = 1'b1; exp_idx = m_idx[IW-1:0]; exp_tag = '0; exp_tgt = '0; exp_vld = 1'b0;
      if (fl) m_idx = 0;
      else if (m_idx == NENT - 1) begin m_sweep = 1'b0; m_idx = 0; end
      else m_idx++;
    end else if (fl) begin
      exp_en = 1'b0;
      m_q.delete();
      m_sweep = 1'b1;
      m_idx = 0;
    end else begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        exp_en = 1'b1; exp_idx = e[AW+IW-1:AW]; exp_tag = e[2*AW-1:AW+IW];
        exp_tgt = e[AW-1:0]; exp_vld = 1'b1;
      end else begin
        exp_en = 1'b0;
      end
      if (v && exp_ready) m_q.push_back({pc, tgt});
    end
    @(negedge clk);
    bus.upd_valid = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [IW-1:0] k_idx;
    #2;
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b exp 0", bus.wr_en); end
    vectors++; if ({bus.wr_index, bus.wr_tag, bus.wr_target, bus.wr_vld} !== '0) begin miscompares++;
      $display("FAIL reset_wr_fields got %h/%h/%h/%b exp all 0", bus.wr_index, bus.wr_tag, bus.wr_target, bus.wr_vld); end
    vectors++; if (bus.flush_busy !== 1'b1) begin miscompares++; $display("FAIL reset_flush_busy got %b exp 1", bus.flush_busy); end
    vectors++; if (bus.lookup_block !== 1'b1) begin miscompares++; $display("FAIL reset_lookup_block got %b exp 1", bus.lookup_block); end
    vectors++; if (bus.upd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_upd_ready got %b exp 0", bus.upd_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < NENT + 1; k++) begin
      cycle(1'b0, '0, '0, 1'b0);
      k_idx = k[IW-1:0];
      vectors++; if (bus.wr_en !== exp_en) begin miscompares++; $display("FAIL init_sweep_wr_en k=%0d got %b exp %b", k, bus.wr_en, exp_en); end
      if (k < NENT) begin
        vectors++; if (bus.wr_en !== 1'b1 || bus.wr_index !== k_idx || bus.wr_vld !== 1'b0 || bus.wr_tag !== '0 || bus.wr_target !== '0) begin
          miscompares++; $display("FAIL init_sweep_write k=%0d got en=%b idx=%0d vld=%b tag=%h tgt=%h exp en=1 idx=%0d vld=0 tag=0 tgt=0",
                                   k, bus.wr_en, bus.wr_index, bus.wr_vld, bus.wr_tag, bus.wr_target, k_idx); end
      end
      vectors++; if (bus.flush_busy !== (k < NENT - 1)) begin miscompares++; $display("FAIL init_sweep_busy k=%0d got %b exp %b", k, bus.flush_busy, (k < NENT - 1)); end
      vectors++; if (bus.upd_ready !== (k >= NENT - 1)) begin miscompares++; $display("FAIL init_sweep_ready k=%0d got %b exp %b", k, bus.upd_ready, (k >= NENT - 1)); end
    end
  endtask

  task automatic test_single_update();
    cycle(1'b1, 16'h1234, 16'h2000, 1'b0);
    vectors++; if (seen_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready got %b exp 1", seen_ready); end
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass got %b exp 0", bus.wr_en); end
    cycle(1'b0, '0, '0, 1'b0);
    vectors++; if ({bus.wr_en, bus.wr_index, bus.wr_tag, bus.wr_target, bus.wr_vld} !== {1'b1, 4'h4, 12'h123, 16'h2000, 1'b1}) begin
      miscompares++; $display("FAIL single_write got en=%b idx=%h tag=%h tgt=%h vld=%b exp en=1 idx=4 tag=123 tgt=2000 vld=1",
                               bus.wr_en, bus.wr_index, bus.wr_tag, bus.wr_target, bus.wr_vld); end
    cycle(1'b0, '0, '0, 1'b0);
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL single_after got %b exp 0", bus.wr_en); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] pcs[6];
    logic [AW-1:0] tgts[6];
    int nw;
    int vw;
    nw = 0;
    for (int i = 0; i < 6; i++) begin pcs[i] = AW'($urandom); tgts[i] = AW'($urandom); end
    for (int c = 0; c < 8; c++) begin
      if (c < 6) cycle(1'b1, pcs[c], tgts[c], 1'b0);
      else cycle(1'b0, '0, '0, 1'b0);
      if (c < 6) begin
        vectors++; if (seen_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready c=%0d got %b exp 1", c, seen_ready); end
      end
      vectors++; if (bus.wr_en !== (c >= 1 && c <= 6)) begin miscompares++; $display("FAIL b2b_wr_en c=%0d got %b exp %b", c, bus.wr_en, (c >= 1 && c <= 6)); end
      if (bus.wr_en === 1'b1 && nw < 6) begin
        vectors++; if ({bus.wr_index, bus.wr_tag, bus.wr_target, bus.wr_vld} !== {pcs[nw][IW-1:0], pcs[nw][AW-1:IW], tgts[nw], 1'b1}) begin
          miscompares++; $display("FAIL b2b_order n=%0d got idx=%h tag=%h tgt=%h exp idx=%h tag=%h tgt=%h",
                                   nw, bus.wr_index, bus.wr_tag, bus.wr_target, pcs[nw][IW-1:0], pcs[nw][AW-1:IW], tgts[nw]); end
        nw++;
      end
    end
    vectors++; if (nw != 6) begin miscompares++; $display("FAIL b2b_count got %0d exp 6", nw); end
    // Five accepted updates followed by a flush: the tail is discarded.
    vw = 0;
    for (int c = 0; c < 6 + NENT + 2; c++) begin
      cycle(c < 5, AW'($urandom), AW'($urandom), c == 5);
      vectors++; if (seen_ready !== exp_ready) begin miscompares++; $display("FAIL flushq_ready c=%0d got %b exp %b", c, seen_ready, exp_ready); end
      vectors++; if (bus.wr_en !== exp_en || (exp_en && {bus.wr_index, bus.wr_tag, bus.wr_target, bus.wr_vld} !== {exp_idx, exp_tag, exp_tgt, exp_vld})) begin
        miscompares++; $display("FAIL flushq_write c=%0d got en=%b idx=%h vld=%b exp en=%b idx=%h vld=%b", c, bus.wr_en, bus.wr_index, bus.wr_vld, exp_en, exp_idx, exp_vld); end
      if (c == 5) begin
        vectors++; if (bus.flush_busy !== 1'b1) begin miscompares++; $display("FAIL flushq_busy got %b exp 1", bus.flush_busy); end
      end
      if (c >= 5 && bus.wr_en === 1'b1 && bus.wr_vld === 1'b1) vw++;
    end
    vectors++; if (vw != 0) begin miscompares++; $display("FAIL flushq_discard got %0d valid writes exp 0", vw); end
  endtask

  task automatic test_flush_with_update();
    int vw;
    vw = 0;
    cycle(1'b1, 16'hBEEF, 16'h4242, 1'b1);
    vectors++; if (seen_ready !== 1'b0) begin miscompares++; $display("FAIL flushupd_ready got %b exp 0", seen_ready); end
    vectors++; if (bus.wr_en !== 1'b0 || bus.flush_busy !== 1'b1) begin miscompares++; $display("FAIL flushupd_edge got en=%b busy=%b exp en=0 busy=1", bus.wr_en, bus.flush_busy); end
    cycle(1'b0, '0, '0, 1'b0);
    vectors++; if (bus.wr_en !== 1'b1 || bus.wr_index !== '0 || bus.wr_vld !== 1'b0) begin
      miscompares++; $display("FAIL flushupd_first got en=%b idx=%0d vld=%b exp en=1 idx=0 vld=0", bus.wr_en, bus.wr_index, bus.wr_vld); end
    for (int c = 0; c < NENT + 3; c++) begin
      cycle(1'b0, '0, '0, 1'b0);
      if (bus.wr_en === 1'b1 && bus.wr_vld === 1'b1) vw++;
    end
    vectors++; if (vw != 0) begin miscompares++; $display("FAIL flushupd_dropped got %0d valid writes exp 0", vw); end
  endtask

  task automatic test_flush_mid_sweep();
    int n;
    bit fired;
    bit fire;
    bit after;
    bit done;
    n = 0; fired = 0; after = 0; done = 0;
    cycle(1'b0, '0, '0, 1'b1);
    for (int c = 0; c < 60 && !done; c++) begin
      fire = !fired && m_sweep && (m_idx == 9);
      cycle(1'b0, '0, '0, fire);
      vectors++; if (bus.wr_en !== exp_en || (exp_en && {bus.wr_index, bus.wr_vld} !== {exp_idx, exp_vld})) begin
        miscompares++; $display("FAIL midsweep_write c=%0d got en=%b idx=%0d vld=%b exp en=%b idx=%0d vld=%b", c, bus.wr_en, bus.wr_index, bus.wr_vld, exp_en, exp_idx, exp_vld); end
      if (bus.wr_en === 1'b1 && bus.wr_vld === 1'b0) n++;
      if (after) begin
        vectors++; if (bus.wr_index !== '0) begin miscompares++; $display("FAIL midsweep_restart got %0d exp 0", bus.wr_index); end
        after = 0;
      end
      if (fire) begin fired = 1; after = 1; end
      if (bus.flush_busy === 1'b0 && n > 0) done = 1;
    end
    vectors++; if (!done) begin miscompares++; $display("FAIL midsweep_timeout got busy=%b exp 0 within 60 cycles", bus.flush_busy); end
    vectors++; if (n != 26) begin miscompares++; $display("FAIL midsweep_count got %0d exp 26", n); end
  endtask

  task automatic test_reset_pulse();
    int vw;
    vw = 0;
    cycle(1'b1, 16'h1111, 16'hA1A1, 1'b0);
    cycle(1'b1, 16'h2222, 16'hA2A2, 1'b0);
    cycle(1'b1, 16'h3333, 16'hA3A3, 1'b0);
    reset_n = 1'b0;
    #1;
    vectors++; if ({bus.wr_en, bus.wr_index, bus.wr_tag, bus.wr_target, bus.wr_vld} !== '0) begin
      miscompares++; $display("FAIL pulse_outputs got en=%b idx=%h tag=%h tgt=%h vld=%b exp all 0", bus.wr_en, bus.wr_index, bus.wr_tag, bus.wr_target, bus.wr_vld); end
    vectors++; if (bus.flush_busy !== 1'b1 || bus.upd_ready !== 1'b0) begin
      miscompares++; $display("FAIL pulse_status got busy=%b ready=%b exp busy=1 ready=0", bus.flush_busy, bus.upd_ready); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < NENT + 4; c++) begin
      cycle(1'b0, '0, '0, 1'b0);
      if (c == 0) begin
        vectors++; if (bus.wr_en !== 1'b1 || bus.wr_index !== '0) begin miscompares++; $display("FAIL pulse_first got en=%b idx=%0d exp en=1 idx=0", bus.wr_en, bus.wr_index); end
      end
      vectors++; if (bus.wr_en !== exp_en) begin miscompares++; $display("FAIL pulse_wr_en c=%0d got %b exp %b", c, bus.wr_en, exp_en); end
      if (bus.wr_en === 1'b1 && bus.wr_vld === 1'b1) vw++;
    end
    vectors++; if (vw != 0) begin miscompares++; $display("FAIL pulse_dropped got %0d valid writes exp 0", vw); end
  endtask

  task automatic test_random();
    bit v;
    bit fl;
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 39) == 0);
      cycle(v, AW'($urandom), AW'($urandom), fl);
      vectors++; if (seen_ready !== exp_ready) begin miscompares++; $display("FAIL rand_ready c=%0d got %b exp %b", c, seen_ready, exp_ready); end
      vectors++; if (bus.wr_en !== exp_en || (exp_en && {bus.wr_index, bus.wr_tag, bus.wr_target, bus.wr_vld} !== {exp_idx, exp_tag, exp_tgt, exp_vld})) begin
        miscompares++; $display("FAIL rand_write c=%0d got en=%b idx=%h tag=%h tgt=%h vld=%b exp en=%b idx=%h tag=%h tgt=%h vld=%b",
                                 c, bus.wr_en, bus.wr_index, bus.wr_tag, bus.wr_target, bus.wr_vld, exp_en, exp_idx, exp_tag, exp_tgt, exp_vld); end
      vectors++; if (bus.flush_busy !== m_sweep || bus.lookup_block !== m_sweep) begin
        miscompares++; $display("FAIL rand_busy c=%0d got busy=%b block=%b exp %b", c, bus.flush_busy, bus.lookup_block, m_sweep); end
    end
  endtask

  initial begin
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_target = '0;
    bus.flush_req  = 1'b0;
    model_reset();
    test_reset();
    test_single_update();
    test_back_to_back();
    test_flush_with_update();
    test_flush_mid_sweep();
    test_reset_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
